// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - decode/pipeline bus of the forwarding and hazard unit
// Optional perf counter signals exist only when FWD_PERF_CNT_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [NUM_SRC*DATA_W-1:0]   id_rf_data;
  logic [REG_AW-1:0]           id_dst;
  logic                        id_wr_en;
  logic                        id_is_load;
  logic [1:0]                  id_res_sel;
  logic [DATA_W-1:0]           ex_alu_result;
  logic [DATA_W-1:0]           ex_pc_incr;
  logic [DATA_W-1:0]           ex_cond_result;
  logic [DATA_W-1:0]           mem_result;
  logic [DATA_W-1:0]           wb_wr_data;
  logic                        flush;
  logic [NUM_SRC*DATA_W-1:0]   fwd_data;
  logic [NUM_SRC*2-1:0]        fwd_sel;
  logic                        stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]                 perf_stall_cnt;
  logic [31:0]                 perf_fwd_cnt;
`endif

  modport master (
    output id_valid, id_src, id_src_used, id_rf_data, id_dst, id_wr_en, id_is_load,
           id_res_sel, ex_alu_result, ex_pc_incr, ex_cond_result, mem_result,
           wb_wr_data, flush,
    input  fwd_data, fwd_sel, stall
`ifdef FWD_PERF_CNT_EN
    , input perf_stall_cnt, perf_fwd_cnt
`endif
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rf_data, id_dst, id_wr_en, id_is_load,
           id_res_sel, ex_alu_result, ex_pc_incr, ex_cond_result, mem_result,
           wb_wr_data, flush,
    output fwd_data, fwd_sel, stall
`ifdef FWD_PERF_CNT_EN
    , output perf_stall_cnt, perf_fwd_cnt
`endif
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding with EX/MEM/WB tag tracking and load-use stall
// Optional FWD_PERF_CNT_EN adds stall and forward-event counters.
module fwd_hazard_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  fwd_hazard_unit_if.slave   bus
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wrEn;
    logic              isLoad;
    logic [1:0]        resSel;
  } tag_t;

  tag_t exTag, memTag, wbTag, idTag;
  logic [DATA_W-1:0]         exResult;
  logic [NUM_SRC*DATA_W-1:0] fwdDataV;
  logic [NUM_SRC*2-1:0]      fwdSelV;
  logic                      loadHit;
  logic                      anyFwd;
  logic                      stallV;

  assign idTag = '{valid: 1'b1, dst: bus.id_dst, wrEn: bus.id_wr_en,
                   isLoad: bus.id_is_load, resSel: bus.id_res_sel};

  always_comb begin
    exResult = '0;
    case (exTag.resSel)
      2'd0:    exResult = bus.ex_alu_result;
      2'd2:    exResult = bus.ex_pc_incr;
      2'd3:    exResult = bus.ex_cond_result;
      default: exResult = '0;
    endcase
  end

  // Youngest producer wins: EX, then MEM, then WB, then the register file.
  always_comb begin
    logic [REG_AW-1:0] src;
    logic              live;
    fwdDataV = '0;
    fwdSelV  = '0;
    loadHit  = 1'b0;
    anyFwd   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src  = bus.id_src[i*REG_AW +: REG_AW];
      live = bus.id_src_used[i] && (src != '0);
      if (live && exTag.valid && exTag.wrEn && exTag.dst == src) begin
        fwdDataV[i*DATA_W +: DATA_W] = exResult;
        fwdSelV[i*2 +: 2]            = 2'd1;
        loadHit                      = loadHit | exTag.isLoad;
      end else if (live && memTag.valid && memTag.wrEn && memTag.dst == src) begin
        fwdDataV[i*DATA_W +: DATA_W] = bus.mem_result;
        fwdSelV[i*2 +: 2]            = 2'd2;
      end else if (live && wbTag.valid && wbTag.wrEn && wbTag.dst == src) begin
        fwdDataV[i*DATA_W +: DATA_W] = bus.wb_wr_data;
        fwdSelV[i*2 +: 2]            = 2'd3;
      end else begin
        fwdDataV[i*DATA_W +: DATA_W] = bus.id_rf_data[i*DATA_W +: DATA_W];
        fwdSelV[i*2 +: 2]            = 2'd0;
      end
      anyFwd = anyFwd | (fwdSelV[i*2 +: 2] != 2'd0);
    end
  end

  assign stallV       = bus.id_valid & ~bus.flush & loadHit;
  assign bus.fwd_data = fwdDataV;
  assign bus.fwd_sel  = fwdSelV;
  assign bus.stall    = stallV;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exTag  <= '0;
      memTag <= '0;
      wbTag  <= '0;
    end else begin
      wbTag  <= memTag;
      memTag <= exTag;
      exTag  <= (bus.id_valid && !stallV && !bus.flush) ? idTag : '0;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stallCnt, fwdCnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stallCnt <= '0;
      fwdCnt   <= '0;
    end else begin
      if (stallV) stallCnt <= stallCnt + 32'd1;
      if (anyFwd) fwdCnt   <= fwdCnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = stallCnt;
  assign bus.perf_fwd_cnt   = fwdCnt;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2)) bus ();

  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] dst, input logic wr, input logic ld, input logic [1:0] rs);
    bus.id_valid    = 1'b1;
    bus.id_dst      = dst;
    bus.id_wr_en    = wr;
    bus.id_is_load  = ld;
    bus.id_res_sel  = rs;
  endtask

  task automatic srcs(input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] used);
    bus.id_src      = {s1, s0};
    bus.id_src_used = used;
  endtask

  initial begin
    bus.id_valid       = 1'b0;
    bus.id_src         = '0;
    bus.id_src_used    = '0;
    bus.id_rf_data     = {32'hBBBB_0001, 32'hAAAA_0000};
    bus.id_dst         = '0;
    bus.id_wr_en       = 1'b0;
    bus.id_is_load     = 1'b0;
    bus.id_res_sel     = '0;
    bus.ex_alu_result  = 32'h0;
    bus.ex_pc_incr     = 32'h0;
    bus.ex_cond_result = 32'h0;
    bus.mem_result     = 32'h0;
    bus.wb_wr_data     = 32'h0;
    bus.flush          = 1'b0;

    // Reset state
    srcs(5'd3, 5'd3, 2'b11);
    #12;
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("rst_sel", {60'd0, bus.fwd_sel}, 64'd0);
    chk("rst_data", bus.fwd_data, 64'hBBBB_0001_AAAA_0000);
`ifdef FWD_PERF_CNT_EN
    chk("rst_perf_stall", {32'd0, bus.perf_stall_cnt}, 64'd0);
    chk("rst_perf_fwd", {32'd0, bus.perf_fwd_cnt}, 64'd0);
`endif
    reset_n = 1'b1;
    tick();

    // ALU producer then dependent consumer through EX, MEM, WB
    issue(5'd3, 1'b1, 1'b0, 2'd0);
    srcs(5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd0, 1'b0, 1'b0, 2'd0);
    srcs(5'd0, 5'd3, 2'b01);
    bus.ex_alu_result = 32'h1234;
    #1;
    chk("alu_ex_sel", {62'd0, bus.fwd_sel[1:0]}, 64'd1);
    chk("alu_ex_data", {32'd0, bus.fwd_data[31:0]}, 64'h1234);
    chk("alu_ex_stall", {63'd0, bus.stall}, 64'd0);
    chk("alu_ex_src1", {32'd0, bus.fwd_data[63:32]}, 64'hBBBB_0001);
    tick();
    bus.mem_result = 32'h5555;
    #1;
    chk("alu_mem_sel", {62'd0, bus.fwd_sel[1:0]}, 64'd2);
    chk("alu_mem_data", {32'd0, bus.fwd_data[31:0]}, 64'h5555);
    tick();
    bus.wb_wr_data = 32'h6666;
    #1;
    chk("alu_wb_sel", {62'd0, bus.fwd_sel[1:0]}, 64'd3);
    chk("alu_wb_data", {32'd0, bus.fwd_data[31:0]}, 64'h6666);
    tick();
    chk("alu_rf_sel", {62'd0, bus.fwd_sel[1:0]}, 64'd0);
    chk("alu_rf_data", {32'd0, bus.fwd_data[31:0]}, 64'hAAAA_0000);

    // Load-use on source 1
    issue(5'd5, 1'b1, 1'b1, 2'd0);
    srcs(5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd6, 1'b1, 1'b0, 2'd0);
    srcs(5'd5, 5'd0, 2'b10);
    #1;
    chk("lu_stall", {63'd0, bus.stall}, 64'd1);
    tick();
    bus.mem_result = 32'hCAFE;
    #1;
    chk("lu_after_stall", {63'd0, bus.stall}, 64'd0);
    chk("lu_mem_sel", {62'd0, bus.fwd_sel[3:2]}, 64'd2);
    chk("lu_mem_data", {32'd0, bus.fwd_data[63:32]}, 64'hCAFE);
`ifdef FWD_PERF_CNT_EN
    chk("lu_perf_stall", {32'd0, bus.perf_stall_cnt}, 64'd1);
`endif
    tick();

    // Priority: r7 produced in WB, MEM and EX
    bus.id_valid = 1'b0;
    srcs(5'd0, 5'd0, 2'b00);
    tick(); tick(); tick();
    issue(5'd7, 1'b1, 1'b0, 2'd0);
    tick();
    issue(5'd7, 1'b1, 1'b0, 2'd0);
    tick();
    issue(5'd7, 1'b1, 1'b0, 2'd2);
    tick();
    issue(5'd0, 1'b0, 1'b0, 2'd0);
    srcs(5'd0, 5'd7, 2'b01);
    bus.ex_pc_incr = 32'h40;
    #1;
    chk("prio_ex_sel", {62'd0, bus.fwd_sel[1:0]}, 64'd1);
    chk("prio_ex_data", {32'd0, bus.fwd_data[31:0]}, 64'h40);
    tick();
    bus.mem_result = 32'h77;
    #1;
    chk("prio_mem_sel", {62'd0, bus.fwd_sel[1:0]}, 64'd2);
    chk("prio_mem_data", {32'd0, bus.fwd_data[31:0]}, 64'h77);

    // r0 guard and reserved res_sel
    issue(5'd0, 1'b1, 1'b0, 2'd0);
    srcs(5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd0, 1'b0, 1'b0, 2'd0);
    srcs(5'd0, 5'd0, 2'b01);
    bus.id_rf_data    = {32'hBBBB_0001, 32'h0};
    bus.ex_alu_result = 32'hFFFF;
    #1;
    chk("r0_sel", {62'd0, bus.fwd_sel[1:0]}, 64'd0);
    chk("r0_data", {32'd0, bus.fwd_data[31:0]}, 64'd0);
    issue(5'd4, 1'b1, 1'b0, 2'd1);
    srcs(5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd0, 1'b0, 1'b0, 2'd0);
    srcs(5'd0, 5'd4, 2'b01);
    #1;
    chk("rsv_sel", {62'd0, bus.fwd_sel[1:0]}, 64'd1);
    chk("rsv_data", {32'd0, bus.fwd_data[31:0]}, 64'd0);

    // Flush during a load-use hazard
    issue(5'd9, 1'b1, 1'b1, 2'd0);
    srcs(5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd10, 1'b1, 1'b0, 2'd0);
    srcs(5'd0, 5'd9, 2'b01);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", {63'd0, bus.stall}, 64'd0);
    tick();
    bus.flush = 1'b0;
    issue(5'd0, 1'b0, 1'b0, 2'd0);
    srcs(5'd9, 5'd10, 2'b11);
    #1;
    chk("flush_ex_bubble", {62'd0, bus.fwd_sel[1:0]}, 64'd0);
    chk("flush_load_mem", {62'd0, bus.fwd_sel[3:2]}, 64'd2);
`ifdef FWD_PERF_CNT_EN
    chk("flush_perf_stall", {32'd0, bus.perf_stall_cnt}, 64'd1);
`endif

    // Asynchronous reset in the middle of a stall
    issue(5'd5, 1'b1, 1'b1, 2'd0);
    srcs(5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd0, 1'b0, 1'b0, 2'd0);
    srcs(5'd0, 5'd5, 2'b01);
    #1;
    chk("mid_stall", {63'd0, bus.stall}, 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("async_rst_sel", {60'd0, bus.fwd_sel}, 64'd0);
    chk("async_rst_data", bus.fwd_data, 64'hBBBB_0001_0000_0000);
    #2;
    reset_n = 1'b1;
    #1;
`ifdef FWD_PERF_CNT_EN
    chk("post_rst_perf_stall", {32'd0, bus.perf_stall_cnt}, 64'd0);
    chk("post_rst_perf_fwd", {32'd0, bus.perf_fwd_cnt}, 64'd0);
`endif
    chk("post_rst_stall", {63'd0, bus.stall}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
